multi_channel_pulse_detector: RTL and testbench

// N_CH independent channels, each detecting rising edges, falling edges and

---
 rtl/multi_channel_pulse_detector.sv | 53 +++++
 tb/tb_multi_channel_pulse_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_detector.sv
// multi_channel_pulse_detector: per-channel edge and windowed pulse-width detection with global accepted-pulse count
module multi_channel_pulse_detector #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int ACT_HIGH = 1,
    parameter int TOT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       a,
    input  logic [CNT_W-1:0]      min_len,
    input  logic [CNT_W-1:0]      max_len,
    output logic [N_CH-1:0]       rise_det,
    output logic [N_CH-1:0]       fall_det,
    output logic [N_CH-1:0]       pulse_det,
    output logic [N_CH*CNT_W-1:0] pulse_len,
    output logic [TOT_W-1:0]      total_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [N_CH-1:0]  act;
    logic [N_CH-1:0]  act_r;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] lo;
    logic [TOT_W-1:0] inc;
    // edges, window check against the run length held before this sample, and per-cycle acceptance count
    always_comb begin
        act = (ACT_HIGH != 0) ? a : ~a;
        lo = (min_len == '0) ? CNT_W'(1) : min_len;
        rise_det = act & ~act_r;
        fall_det = ~act & act_r;
        pulse_det = '0;
        pulse_len = '0;
        inc = '0;
        for (int i = 0; i < N_CH; i++) begin
            pulse_len[i*CNT_W +: CNT_W] = cnt[i];
            pulse_det[i] = fall_det[i] & (cnt[i] >= lo) & (cnt[i] <= max_len) & (cnt[i] != CNT_MAX);
            inc = inc + TOT_W'(pulse_det[i]);
        end
    end
    // previous active level, saturating run counters and the wrapping total
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_r <= '0;
            total_cnt <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            act_r <= act;
            total_cnt <= total_cnt + inc;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= !act[i] ? '0 : !act_r[i] ? CNT_W'(1) : (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multi_channel_pulse_detector.sv
// tb_multi_channel_pulse_detector: directed checks of edges, windowed pulses, saturation, reset and active-low mode
module tb_multi_channel_pulse_detector;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  min_len, max_len;
    logic [3:0]  rise_det, fall_det, pulse_det;
    logic [15:0] pulse_len, total_cnt;
    logic [0:0]  b;
    logic [7:0]  lmin, lmax;
    logic [0:0]  l_rise, l_fall, l_pulse;
    logic [7:0]  l_len;
    logic [15:0] l_tot;
    int checks = 0;
    int errors = 0;
    logic [15:0] seq, rise_e, fall_e, p11_e, p24_e;
    logic [6:0]  lseq, lrise_e, lpulse_e;

    always #5 clk = ~clk;

    multi_channel_pulse_detector #(.N_CH(4), .CNT_W(4), .ACT_HIGH(1), .TOT_W(16)) u_dut (
        .clk(clk), .rst(rst), .a(a), .min_len(min_len), .max_len(max_len),
        .rise_det(rise_det), .fall_det(fall_det), .pulse_det(pulse_det),
        .pulse_len(pulse_len), .total_cnt(total_cnt)
    );

    multi_channel_pulse_detector #(.N_CH(1), .CNT_W(8), .ACT_HIGH(0), .TOT_W(16)) u_low (
        .clk(clk), .rst(rst), .a(b), .min_len(lmin), .max_len(lmax),
        .rise_det(l_rise), .fall_det(l_fall), .pulse_det(l_pulse),
        .pulse_len(l_len), .total_cnt(l_tot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        seq      = 16'b1001011011110001;
        rise_e   = 16'b1001010010000001;
        fall_e   = 16'b0100100100001000;
        p11_e    = 16'b0100100000000000;
        p24_e    = 16'b0000000100001000;
        lseq     = 7'b1100111;
        lrise_e  = 7'b0010000;
        lpulse_e = 7'b0000100;
        a = '0; b = 1'b1; min_len = 4'd1; max_len = 4'd1; lmin = 8'd2; lmax = 8'd2;

        do_reset();
        #1;
        chk("reset_total", total_cnt, 0);
        chk("reset_len", pulse_len, 0);
        chk("reset_fall", fall_det, 0);
        chk("reset_pulse", pulse_det, 0);

        for (int i = 0; i < 16; i++) begin
            a = {3'b000, seq[15-i]};
            #1;
            chk($sformatf("t1_rise_%0d", i), rise_det, {3'b000, rise_e[15-i]});
            chk($sformatf("t1_fall_%0d", i), fall_det, {3'b000, fall_e[15-i]});
            chk($sformatf("t1_pulse_%0d", i), pulse_det, {3'b000, p11_e[15-i]});
            tick();
        end
        chk("t1_total", total_cnt, 2);

        a = '0; min_len = 4'd2; max_len = 4'd4;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a = {3'b000, seq[15-i]};
            #1;
            chk($sformatf("t2_pulse_%0d", i), pulse_det, {3'b000, p24_e[15-i]});
            if (i == 7) chk("t2_len7", pulse_len[3:0], 2);
            if (i == 12) chk("t2_len12", pulse_len[3:0], 4);
            tick();
        end
        chk("t2_total", total_cnt, 2);

        a = '0; min_len = 4'd1; max_len = 4'd15;
        do_reset();
        a = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        chk("t3_sat_len", pulse_len[3:0], 15);
        a = '0;
        #1;
        chk("t3_fall", fall_det, 4'b0001);
        chk("t3_pulse", pulse_det, 0);
        tick();
        chk("t3_total", total_cnt, 0);

        min_len = 4'd3; max_len = 4'd3;
        do_reset();
        a = 4'hf;
        tick(); tick(); tick();
        a = '0;
        #1;
        chk("t4_pulse", pulse_det, 4'hf);
        chk("t4_len", pulse_len, 16'h3333);
        chk("t4_total_before", total_cnt, 0);
        tick();
        chk("t4_total", total_cnt, 4);

        min_len = 4'd2; max_len = 4'd2;
        a = 4'b0001; rst = 1'b0;
        #1;
        chk("t6_rise_in_reset", rise_det, 4'b0001);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t6_rise_release", rise_det, 4'b0001);
        chk("t6_len_release", pulse_len[3:0], 0);
        tick();
        chk("t6_rise_second", rise_det, 0);
        chk("t6_len_second", pulse_len[3:0], 1);
        tick();
        a = '0;
        #1;
        chk("t6_fall", fall_det, 4'b0001);
        chk("t6_pulse", pulse_det, 4'b0001);
        chk("t6_len", pulse_len[3:0], 2);
        tick();
        chk("t6_total", total_cnt, 1);
        min_len = 4'd3; max_len = 4'd2;
        a = 4'b0001;
        tick(); tick();
        a = '0;
        #1;
        chk("t6_inv_fall2", fall_det, 4'b0001);
        chk("t6_inv_pulse2", pulse_det, 0);
        tick();
        a = 4'b0001;
        tick(); tick(); tick();
        a = '0;
        #1;
        chk("t6_inv_fall3", fall_det, 4'b0001);
        chk("t6_inv_pulse3", pulse_det, 0);
        tick();
        chk("t6_inv_total", total_cnt, 1);

        b = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            b = lseq[6-i];
            #1;
            chk($sformatf("t5_rise_%0d", i), l_rise, lrise_e[6-i]);
            chk($sformatf("t5_pulse_%0d", i), l_pulse, lpulse_e[6-i]);
            if (i == 4) chk("t5_len", l_len, 2);
            tick();
        end
        chk("t5_total", l_tot, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
